// File: rtl/basic_gates_pkg.sv
// Shared definitions for the mux-only gate unit: gate-select enum,
// mux data constants and the default operand width.
package basic_gates_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;

    localparam logic MUX_ZERO = 1'b0;
    localparam logic MUX_ONE  = 1'b1;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_NAND = 3'd2,
        GATE_NOR  = 3'd3,
        GATE_XOR  = 3'd4,
        GATE_XNOR = 3'd5
    } gate_sel_e;

endpackage

// File: rtl/basic_gates_mux_mux2.sv
// mux2: single-bit 2:1 multiplexer, the only logic primitive used by the gate unit.
// Ports: s (select), d0 (data when s=0), d1 (data when s=1), y_c (combinational result).
module mux2 (
    input  logic s,
    input  logic d0,
    input  logic d1,
    output logic y_c
);

    assign y_c = s ? d1 : d0;

endmodule

// File: rtl/basic_gates_mux.sv
// basic_gates_mux: bitwise AND/OR (and optionally NAND/NOR/XOR/XNOR) built
// purely from mux2 instances, with results registered on one clock.
// Optional macro: BASIC_GATES_EXT_EN adds the NAND/NOR/XOR/XNOR outputs.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears every output)
//   in_valid  qualifies a/b this cycle
//   a         operand A, drives mux selects
//   b         operand B, drives mux data
//   out_valid results were loaded from a valid sample at the last edge
//   and_out, or_out                       registered a AND b, a OR b
//   nand_out, nor_out, xor_out, xnor_out  registered extended gates (macro only)
module basic_gates_mux
    import basic_gates_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] and_out,
`ifdef BASIC_GATES_EXT_EN
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] nand_out,
    output logic [WIDTH-1:0] nor_out,
    output logic [WIDTH-1:0] xor_out,
    output logic [WIDTH-1:0] xnor_out
`else
    output logic [WIDTH-1:0] or_out
`endif
);

    logic [WIDTH-1:0] and_c;
    logic [WIDTH-1:0] or_c;

    // Per-bit mux trees; a[i] is always the select, b[i] (or its inverse) the data.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        mux2 u_and (.s(a[i]), .d0(MUX_ZERO), .d1(b[i]),    .y_c(and_c[i]));
        mux2 u_or  (.s(a[i]), .d0(b[i]),     .d1(MUX_ONE), .y_c(or_c[i]));
    end

`ifdef BASIC_GATES_EXT_EN
    logic [WIDTH-1:0] not_b_c;
    logic [WIDTH-1:0] nand_c;
    logic [WIDTH-1:0] nor_c;
    logic [WIDTH-1:0] xor_c;
    logic [WIDTH-1:0] xnor_c;

    // Inversion is itself a mux (select on b), shared by every extended gate.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ext_bit
        mux2 u_not_b (.s(b[i]), .d0(MUX_ONE),    .d1(MUX_ZERO),   .y_c(not_b_c[i]));
        mux2 u_nand  (.s(a[i]), .d0(MUX_ONE),    .d1(not_b_c[i]), .y_c(nand_c[i]));
        mux2 u_nor   (.s(a[i]), .d0(not_b_c[i]), .d1(MUX_ZERO),   .y_c(nor_c[i]));
        mux2 u_xor   (.s(a[i]), .d0(b[i]),       .d1(not_b_c[i]), .y_c(xor_c[i]));
        mux2 u_xnor  (.s(a[i]), .d0(not_b_c[i]), .d1(b[i]),       .y_c(xnor_c[i]));
    end
`endif

    // Result registers: reset wins, a valid sample loads, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            and_out   <= '0;
            or_out    <= '0;
`ifdef BASIC_GATES_EXT_EN
            nand_out  <= '0;
            nor_out   <= '0;
            xor_out   <= '0;
            xnor_out  <= '0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                and_out  <= and_c;
                or_out   <= or_c;
`ifdef BASIC_GATES_EXT_EN
                nand_out <= nand_c;
                nor_out  <= nor_c;
                xor_out  <= xor_c;
                xnor_out <= xnor_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_basic_gates_mux.sv
// Directed self-checking bench for basic_gates_mux at WIDTH=1 and WIDTH=4.
module tb_basic_gates_mux;

    logic       clk;
    logic       rst;
    logic       in_valid1;
    logic       a1;
    logic       b1;
    logic       out_valid1;
    logic       and1;
    logic       or1;
    logic       in_valid4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       out_valid4;
    logic [3:0] and4;
    logic [3:0] or4;
`ifdef BASIC_GATES_EXT_EN
    logic       nand1, nor1, xor1, xnor1;
    logic [3:0] nand4, nor4, xor4, xnor4;
`endif

    int checks;
    int errors;

    basic_gates_mux #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .a(a1), .b(b1),
        .out_valid(out_valid1), .and_out(and1),
`ifdef BASIC_GATES_EXT_EN
        .or_out(or1), .nand_out(nand1), .nor_out(nor1), .xor_out(xor1), .xnor_out(xnor1)
`else
        .or_out(or1)
`endif
    );

    basic_gates_mux #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .a(a4), .b(b4),
        .out_valid(out_valid4), .and_out(and4),
`ifdef BASIC_GATES_EXT_EN
        .or_out(or4), .nand_out(nand4), .nor_out(nor4), .xor_out(xor4), .xnor_out(xnor4)
`else
        .or_out(or4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
        tick();
        tick();
        checks++;
        if (out_valid1 !== 1'b0 || and1 !== 1'b0 || or1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_w1 got v=%b and=%b or=%b want 0 0 0", out_valid1, and1, or1);
        end
        checks++;
        if (out_valid4 !== 1'b0 || and4 !== 4'h0 || or4 !== 4'h0) begin
            errors++;
            $display("FAIL reset_w4 got v=%b and=%h or=%h want 0 0 0", out_valid4, and4, or4);
        end
`ifdef BASIC_GATES_EXT_EN
        checks++;
        if (nand1 !== 1'b0 || nor1 !== 1'b0 || xor1 !== 1'b0 || xnor1 !== 1'b0 ||
            nand4 !== 4'h0 || nor4 !== 4'h0 || xor4 !== 4'h0 || xnor4 !== 4'h0) begin
            errors++;
            $display("FAIL reset_ext got %b%b%b%b %h%h%h%h want all 0",
                     nand1, nor1, xor1, xnor1, nand4, nor4, xor4, xnor4);
        end
`endif
        rst = 1'b0; in_valid1 = 1'b0; in_valid4 = 1'b0;
    endtask

    task automatic test_truth_table();
        // {a,b} and expected {and,or,nand,nor,xor,xnor}
        logic [1:0] vec [4];
        logic [5:0] exp [4];
        vec[0] = 2'b00; exp[0] = 6'b00_11_01;
        vec[1] = 2'b01; exp[1] = 6'b01_10_10;
        vec[2] = 2'b11; exp[2] = 6'b11_00_01;
        vec[3] = 2'b10; exp[3] = 6'b01_10_10;
        for (int i = 0; i < 4; i++) begin
            in_valid1 = 1'b1; a1 = vec[i][1]; b1 = vec[i][0];
            tick();
            checks++;
            if (out_valid1 !== 1'b1 || and1 !== exp[i][5] || or1 !== exp[i][4]) begin
                errors++;
                $display("FAIL truth_%b got v=%b and=%b or=%b want 1 %b %b",
                         vec[i], out_valid1, and1, or1, exp[i][5], exp[i][4]);
            end
`ifdef BASIC_GATES_EXT_EN
            checks++;
            if ({nand1, nor1, xor1, xnor1} !== exp[i][3:0]) begin
                errors++;
                $display("FAIL truth_ext_%b got %b want %b",
                         vec[i], {nand1, nor1, xor1, xnor1}, exp[i][3:0]);
            end
`endif
        end
        in_valid1 = 1'b0;
    endtask

    task automatic test_hold();
        in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick();
        in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        tick();
        checks++;
        if (out_valid1 !== 1'b0 || and1 !== 1'b1 || or1 !== 1'b1) begin
            errors++;
            $display("FAIL hold got v=%b and=%b or=%b want 0 1 1", out_valid1, and1, or1);
        end
        tick();
        checks++;
        if (out_valid1 !== 1'b0 || and1 !== 1'b1 || or1 !== 1'b1) begin
            errors++;
            $display("FAIL hold2 got v=%b and=%b or=%b want 0 1 1", out_valid1, and1, or1);
        end
    endtask

    task automatic test_back_to_back();
        in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid1 !== 1'b1 || and1 !== 1'b0 || or1 !== 1'b1) begin
                errors++;
                $display("FAIL repeat_%0d got v=%b and=%b or=%b want 1 0 1",
                         i, out_valid1, and1, or1);
            end
        end
        in_valid1 = 1'b0;
    endtask

    task automatic test_width4();
        in_valid4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
        tick();
        checks++;
        if (out_valid4 !== 1'b1 || and4 !== 4'b1000 || or4 !== 4'b1110) begin
            errors++;
            $display("FAIL w4_a got v=%b and=%b or=%b want 1 1000 1110", out_valid4, and4, or4);
        end
`ifdef BASIC_GATES_EXT_EN
        checks++;
        if (nand4 !== 4'b0111 || nor4 !== 4'b0001 || xor4 !== 4'b0110 || xnor4 !== 4'b1001) begin
            errors++;
            $display("FAIL w4_ext got nand=%b nor=%b xor=%b xnor=%b want 0111 0001 0110 1001",
                     nand4, nor4, xor4, xnor4);
        end
`endif
        a4 = 4'b0101; b4 = 4'b0011;
        tick();
        checks++;
        if (out_valid4 !== 1'b1 || and4 !== 4'b0001 || or4 !== 4'b0111) begin
            errors++;
            $display("FAIL w4_b got v=%b and=%b or=%b want 1 0001 0111", out_valid4, and4, or4);
        end
        in_valid4 = 1'b0;
        tick();
        checks++;
        if (out_valid4 !== 1'b0 || and4 !== 4'b0001 || or4 !== 4'b0111) begin
            errors++;
            $display("FAIL w4_hold got v=%b and=%b or=%b want 0 0001 0111", out_valid4, and4, or4);
        end
    endtask

    task automatic test_mid_reset();
        in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick();
        checks++;
        if (and1 !== 1'b1 || or1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got and=%b or=%b want 1 1", and1, or1);
        end
        // Reset must beat the still-asserted valid sample.
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid1 !== 1'b0 || and1 !== 1'b0 || or1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got v=%b and=%b or=%b want 0 0 0", out_valid1, and1, or1);
        end
        rst = 1'b0; a1 = 1'b0; b1 = 1'b1;
        tick();
        checks++;
        if (out_valid1 !== 1'b1 || and1 !== 1'b0 || or1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_post got v=%b and=%b or=%b want 1 0 1", out_valid1, and1, or1);
        end
        in_valid1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        #2;
        test_reset();
        test_truth_table();
        test_hold();
        test_back_to_back();
        test_width4();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
